// File: rtl/stream_check_if.sv
// Valid/ready byte-stream link between a stream source (master) and a sink (slave).
interface stream_check_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/stream_check.sv
// Stream sink: applies a backpressure pattern and checks accepted data forms a +1 sequence.
// Optional macro STREAM_CHECK_RANDOM_READY_EN swaps the ON/OFF pattern for a 16-bit LFSR.
module stream_check #(
   parameter int DATA_W    = 8,
   parameter int CNT_W     = 16,
   parameter int READY_ON  = 4,
   parameter int READY_OFF = 0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_enable,
   stream_check_if.slave     s_if,
   output logic              o_locked,
   output logic [CNT_W-1:0]  o_xfer_cnt,
   output logic [CNT_W-1:0]  o_err_cnt,
   output logic              o_err,
   output logic [DATA_W-1:0] o_err_data,
   output logic [DATA_W-1:0] o_err_exp
);
   typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;

   state_t             state_q;
   logic               ready_q;
   logic               locked_q;
   logic               err_q;
   logic [CNT_W-1:0]   xfer_cnt_q;
   logic [CNT_W-1:0]   err_cnt_q;
   logic [DATA_W-1:0]  exp_q;
   logic [DATA_W-1:0]  err_data_q;
   logic [DATA_W-1:0]  err_exp_q;

   logic               xfer;
   logic               mismatch;
   logic [DATA_W-1:0]  data_inc;
   logic [CNT_W-1:0]   xfer_cnt_d;
   logic [CNT_W-1:0]   err_cnt_d;
   logic               ready_d;

   assign xfer       = s_if.valid && ready_q;
   assign mismatch   = (s_if.data != exp_q);
   assign data_inc   = s_if.data + DATA_W'(1);
   assign xfer_cnt_d = (xfer_cnt_q == '1) ? xfer_cnt_q : xfer_cnt_q + CNT_W'(1);
   assign err_cnt_d  = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_W'(1);

`ifdef STREAM_CHECK_RANDOM_READY_EN
   logic [15:0] lfsr_q;
   logic        lfsr_fb;

   assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   assign ready_d = lfsr_q[0];
`else
   localparam int PERIOD = READY_ON + READY_OFF;
   localparam int PAT_W  = $clog2(PERIOD + 1);

   logic [PAT_W-1:0] pat_q;
   logic [PAT_W-1:0] pat_d;

   // Phase 0..READY_ON-1 is the ON window, the rest of the period is OFF.
   assign ready_d = (pat_q < PAT_W'(READY_ON));
   assign pat_d   = (pat_q == PAT_W'(PERIOD - 1)) ? '0 : pat_q + PAT_W'(1);
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         ready_q    <= 1'b0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         xfer_cnt_q <= '0;
         err_cnt_q  <= '0;
         exp_q      <= '0;
         err_data_q <= '0;
         err_exp_q  <= '0;
`ifdef STREAM_CHECK_RANDOM_READY_EN
         lfsr_q     <= 16'hACE1;
`else
         pat_q      <= '0;
`endif
      end else begin
         if (xfer) begin
            xfer_cnt_q <= xfer_cnt_d;
            exp_q      <= data_inc;
            if (state_q == SYNC) begin
               locked_q <= 1'b1;
            end else if (mismatch) begin
               err_cnt_q <= err_cnt_d;
               if (!err_q) begin
                  err_q      <= 1'b1;
                  err_data_q <= s_if.data;
                  err_exp_q  <= exp_q;
               end
            end
         end

         // Disable wins over a same-edge lock so the next cycle is a clean IDLE.
         if (!i_enable) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            locked_q <= 1'b0;
`ifndef STREAM_CHECK_RANDOM_READY_EN
            pat_q    <= '0;
`endif
         end else begin
            ready_q <= ready_d;
`ifdef STREAM_CHECK_RANDOM_READY_EN
            lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
`else
            pat_q   <= pat_d;
`endif
            if (state_q == IDLE) begin
               state_q <= SYNC;
            end else if (xfer && state_q == SYNC) begin
               state_q <= CHECK;
            end
         end
      end
   end

   assign s_if.ready = ready_q;
   assign o_locked   = locked_q;
   assign o_xfer_cnt = xfer_cnt_q;
   assign o_err_cnt  = err_cnt_q;
   assign o_err      = err_q;
   assign o_err_data = err_data_q;
   assign o_err_exp  = err_exp_q;
endmodule

// File: tb/tb_stream_check.sv
// Directed bench for stream_check: vector table plus pattern, saturation and reset sequences.
module tb_stream_check;
   logic clk;
   logic rst;
   logic en_a, en_b, en_c;

   stream_check_if #(.DATA_W(8)) if_a ();
   stream_check_if #(.DATA_W(8)) if_b ();
   stream_check_if #(.DATA_W(8)) if_c ();

   logic        lck_a, err_a;
   logic [15:0] xc_a, ec_a;
   logic [7:0]  ed_a, ee_a;
   logic        lck_b, err_b;
   logic [15:0] xc_b, ec_b;
   logic [7:0]  ed_b, ee_b;
   logic        lck_c, err_c;
   logic [2:0]  xc_c, ec_c;
   logic [7:0]  ed_c, ee_c;

   stream_check dut_a (
      .i_clk(clk), .i_rst(rst), .i_enable(en_a), .s_if(if_a),
      .o_locked(lck_a), .o_xfer_cnt(xc_a), .o_err_cnt(ec_a), .o_err(err_a),
      .o_err_data(ed_a), .o_err_exp(ee_a)
   );

   stream_check #(.READY_ON(2), .READY_OFF(3)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_enable(en_b), .s_if(if_b),
      .o_locked(lck_b), .o_xfer_cnt(xc_b), .o_err_cnt(ec_b), .o_err(err_b),
      .o_err_data(ed_b), .o_err_exp(ee_b)
   );

   stream_check #(.CNT_W(3)) dut_c (
      .i_clk(clk), .i_rst(rst), .i_enable(en_c), .s_if(if_c),
      .o_locked(lck_c), .o_xfer_cnt(xc_c), .o_err_cnt(ec_c), .o_err(err_c),
      .o_err_data(ed_c), .o_err_exp(ee_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       vld;
      logic [7:0] data;
      logic       rdy;
      logic       lck;
      int         xfer;
      int         errc;
      logic       err;
      logic [7:0] ed;
      logic [7:0] ee;
   } vec_t;

   vec_t tbl [18];
   int   n_vec;
   int   n_bad;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   initial begin
      logic took;
      logic r;
      n_vec = 0;
      n_bad = 0;
      rst = 1'b1;
      en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
      if_a.valid = 1'b0; if_a.data = 8'h00;
      if_b.valid = 1'b0; if_b.data = 8'h00;
      if_c.valid = 1'b0; if_c.data = 8'h00;

      //         en vld data   rdy lck xfer errc err ed     ee
      tbl[0]  = '{0, 0, 8'h00, 0, 0, 0,  0, 0, 8'h00, 8'h00};
      tbl[1]  = '{1, 1, 8'h03, 1, 0, 0,  0, 0, 8'h00, 8'h00};
      tbl[2]  = '{1, 1, 8'h03, 1, 1, 1,  0, 0, 8'h00, 8'h00};
      tbl[3]  = '{1, 1, 8'h04, 1, 1, 2,  0, 0, 8'h00, 8'h00};
      tbl[4]  = '{1, 1, 8'h05, 1, 1, 3,  0, 0, 8'h00, 8'h00};
      tbl[5]  = '{1, 1, 8'h07, 1, 1, 4,  1, 1, 8'h07, 8'h06};
      tbl[6]  = '{1, 1, 8'h08, 1, 1, 5,  1, 1, 8'h07, 8'h06};
      tbl[7]  = '{1, 0, 8'h63, 1, 1, 5,  1, 1, 8'h07, 8'h06};
      tbl[8]  = '{1, 1, 8'h09, 1, 1, 6,  1, 1, 8'h07, 8'h06};
      tbl[9]  = '{0, 1, 8'h0A, 0, 0, 7,  1, 1, 8'h07, 8'h06};
      tbl[10] = '{0, 1, 8'h0B, 0, 0, 7,  1, 1, 8'h07, 8'h06};
      tbl[11] = '{1, 1, 8'hFE, 1, 0, 7,  1, 1, 8'h07, 8'h06};
      tbl[12] = '{1, 1, 8'hFE, 1, 1, 8,  1, 1, 8'h07, 8'h06};
      tbl[13] = '{1, 1, 8'hFF, 1, 1, 9,  1, 1, 8'h07, 8'h06};
      tbl[14] = '{1, 1, 8'h00, 1, 1, 10, 1, 1, 8'h07, 8'h06};
      tbl[15] = '{1, 1, 8'h01, 1, 1, 11, 1, 1, 8'h07, 8'h06};
      tbl[16] = '{1, 1, 8'h01, 1, 1, 12, 2, 1, 8'h07, 8'h06};
      tbl[17] = '{1, 1, 8'h02, 1, 1, 13, 2, 1, 8'h07, 8'h06};

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset ready",  32'(if_a.ready), 0);
      check("reset locked", 32'(lck_a), 0);
      check("reset xfer",   32'(xc_a), 0);
      check("reset errcnt", 32'(ec_a), 0);
      check("reset err",    32'(err_a), 0);
      check("reset errdat", 32'(ed_a), 0);
      check("reset errexp", 32'(ee_a), 0);
      $display("reset: ready=%0d locked=%0d xfer=%0d err=%0d", if_a.ready, lck_a, xc_a, ec_a);

      for (int i = 0; i < 18; i++) begin
         en_a       = tbl[i].en;
         if_a.valid = tbl[i].vld;
         if_a.data  = tbl[i].data;
         @(posedge clk);
         #1;
         check($sformatf("row%0d ready", i),  32'(if_a.ready), 32'(tbl[i].rdy));
         check($sformatf("row%0d locked", i), 32'(lck_a), 32'(tbl[i].lck));
         check($sformatf("row%0d xfer", i),   32'(xc_a), 32'(tbl[i].xfer));
         check($sformatf("row%0d errcnt", i), 32'(ec_a), 32'(tbl[i].errc));
         check($sformatf("row%0d err", i),    32'(err_a), 32'(tbl[i].err));
         check($sformatf("row%0d errdat", i), 32'(ed_a), 32'(tbl[i].ed));
         check($sformatf("row%0d errexp", i), 32'(ee_a), 32'(tbl[i].ee));
         $display("row%0d: en=%0d vld=%0d data=%02h -> ready=%0d locked=%0d xfer=%0d err=%0d",
                  i, tbl[i].en, tbl[i].vld, tbl[i].data, if_a.ready, lck_a, xc_a, ec_a);
      end

      // ON=2/OFF=3 pattern with an always-valid counting source
      en_b = 1'b1;
      if_b.valid = 1'b1;
      if_b.data = 8'h00;
      took = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1;
         if (took) if_b.data = if_b.data + 8'd1;
         r = if_b.ready;
         check($sformatf("pattern cyc%0d ready", i), 32'(r), 32'((i % 5) < 2));
         took = r;
      end
      check("pattern xfer",   32'(xc_b), 10);
      check("pattern errcnt", 32'(ec_b), 0);
      check("pattern locked", 32'(lck_b), 1);
      $display("pattern: xfer=%0d err=%0d", xc_b, ec_b);
      en_b = 1'b0;
      if_b.valid = 1'b0;

      // Constant data: one seed then repeated mismatches drive both counters to saturation
      en_c = 1'b1;
      if_c.valid = 1'b1;
      if_c.data = 8'h05;
      repeat (5) @(posedge clk);
      #1;
      check("sat mid xfer",   32'(xc_c), 4);
      check("sat mid errcnt", 32'(ec_c), 3);
      repeat (9) @(posedge clk);
      #1;
      check("sat xfer",   32'(xc_c), 7);
      check("sat errcnt", 32'(ec_c), 7);
      check("sat errdat", 32'(ed_c), 8'h05);
      check("sat errexp", 32'(ee_c), 8'h06);
      $display("saturate: xfer=%0d err=%0d", xc_c, ec_c);
      en_c = 1'b0;
      if_c.valid = 1'b0;

      // Reset on an edge that would otherwise be a transfer
      check("pre-rst ready", 32'(if_a.ready), 1);
      rst = 1'b1;
      if_a.valid = 1'b1;
      if_a.data = 8'h03;
      @(posedge clk);
      #1;
      check("rst-xfer xfer",   32'(xc_a), 0);
      check("rst-xfer errcnt", 32'(ec_a), 0);
      check("rst-xfer err",    32'(err_a), 0);
      check("rst-xfer ready",  32'(if_a.ready), 0);
      check("rst-xfer locked", 32'(lck_a), 0);
      $display("reset mid-transfer: xfer=%0d err=%0d", xc_a, ec_a);
      rst = 1'b0;
      en_a = 1'b0;
      if_a.valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
